sign_restore: RTL and testbench
===============================

Name: sign_restore

Overview:
- Output stage of the shift-add multiplier; inverse of the operand sign-stripping front end.
- Captures operand signs when a multiply starts, waits for the unsigned magnitude product from the shift-add core, then reapplies the sign in two's complement.
- Presents the signed result on a valid/ready interface to downstream logic.

Parameters:
- W, 11, operand width including sign bit.
- PW, 2*W-1 (21), width of the unsigned magnitude product from the core. Operand magnitudes are at most 2^(W-1) (|-1024| = 1024), so the product can reach 2^20.
- RW, 2*W (22), width of the signed result; holds +2^20 without overflow.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse, new multiply launched; samples x_sign, y_sign and enable
- x_sign  input  1  sign bit (bit W-1) of the original multiplicand
- y_sign  input  1  sign bit of the original multiplier
- enable  input  1  1 = apply sign correction; 0 = pass the magnitude through as unsigned
- start_ready  output  1  block can accept start this cycle
- mag_valid  input  1  core's magnitude product is valid (single-cycle pulse)
- mag_product  input  PW  unsigned magnitude product
- result  output  RW  signed product, registered
- result_neg  output  1  result is strictly negative
- result_valid  output  1  result held valid
- result_ready  input  1  downstream accepts result
- seq_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0) sets:
  - state = IDLE;
  - result = 0, result_neg = 0, result_valid = 0, seq_err = 0;
  - start_ready = 1 and the internal sign and enable registers = 0.
  - Reset is effective immediately in any state; an in-flight multiply is discarded with no partial result.
- State machine states: IDLE, ARMED, OUT.
  - start_ready = 1 in IDLE, and in OUT when result_ready = 1. Otherwise 0.
  - IDLE, start=1 → ARMED. Latch neg_q = x_sign ^ y_sign and en_q = enable.
  - ARMED, mag_valid=1 → OUT. Register the result on that edge:
    - en_q=1 and neg_q=1: result = ~zext(mag_product) + 1 (RW bits).
    - Otherwise: result = zext(mag_product).
    - result_valid = 1 from the next cycle; latency is exactly 1 clock from the mag_valid edge.
  - OUT, result_ready=1, start=0 → IDLE; result_valid drops the next cycle.
  - OUT, result_ready=1, start=1 → ARMED with the new signs latched; back-to-back operation with no bubble.
  - OUT, result_ready=0: result, result_neg and result_valid hold stable. mag_valid and start are ignored.
- Zero product: result = 0 and result_neg = 0 regardless of neg_q (no negative zero).
- result_neg = en_q & neg_q & (mag_product != 0), registered with result.
- Arithmetic:
  - Magnitude is zero-extended to RW before negation.
  - Maximum negative result is -(2^20), so no overflow is possible for PW=21, RW=22.
- Protocol errors set seq_err, which stays set until reset:
  - mag_valid in IDLE or OUT is ignored and sets seq_err.
  - start in ARMED is ignored and sets seq_err; the latched signs are unchanged.
  - start in OUT while result_ready=0 is ignored and sets seq_err.
- Simultaneous start and mag_valid in ARMED: mag_valid is processed (→ OUT) and the start error rule applies.

Test Plan:
- -5 × 7: start with x_sign=1, y_sign=0, enable=1; mag_valid with mag_product=35 → one cycle later result=22'h3FFFDD, result_neg=1, result_valid=1.
- -1024 × -1024: signs 1,1, mag_product=21'h100000 → result=22'h100000, result_neg=0. Then signs 1,0 with the same magnitude → result=22'h300000, result_neg=1.
- Zero and bypass:
  - signs 1,0 with mag_product=0 → result=0, result_neg=0.
  - enable=0 with signs 1,0 and mag_product=35 → result=35, result_neg=0.
- Backpressure and back-to-back: hold result_ready=0 for 5 cycles → result stable and start_ready=0. Then raise result_ready together with start → state goes to ARMED with no idle cycle, and the next result is corrected with the new signs.
- Errors and reset:
  - mag_valid while IDLE → seq_err=1 and stays set.
  - Assert rst_n=0 while ARMED → all outputs return to 0 asynchronously and start_ready=1. A following mag_valid does not produce result_valid.

Source files
------------

// File: rtl/sign_restore.sv
// Output stage of the shift-add multiplier: latches operand signs at start,
// reapplies the sign to the unsigned magnitude product and hands it off valid/ready.
module sign_restore #(
  parameter int W  = 11,
  parameter int PW = 2*W-1,
  parameter int RW = 2*W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          x_sign,
  input  logic          y_sign,
  input  logic          enable,
  output logic          start_ready,
  input  logic          mag_valid,
  input  logic [PW-1:0] mag_product,
  output logic [RW-1:0] result,
  output logic          result_neg,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          seq_err
);

  // state | meaning
  // IDLE  | no multiply in flight, start accepted
  // ARMED | signs latched, waiting for the core's magnitude product
  // OUT   | signed result presented, waiting for downstream acceptance
  typedef enum logic [1:0] {IDLE, ARMED, OUT} state_t;

  state_t        state, state_d;
  logic          neg_q, en_q;
  logic          load_signs, load_result, err_set, valid_d;
  logic [RW-1:0] mag_ext, result_d;
  logic          neg_d;

  assign mag_ext  = {{(RW-PW){1'b0}}, mag_product};
  // Negating zero yields zero, so no negative zero can appear.
  assign result_d = (en_q && neg_q) ? (~mag_ext + 1'b1) : mag_ext;
  assign neg_d    = en_q & neg_q & (mag_product != '0);

  always_comb begin
    state_d     = state;
    load_signs  = 1'b0;
    load_result = 1'b0;
    err_set     = 1'b0;
    valid_d     = result_valid;
    start_ready = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (mag_valid) err_set = 1'b1;
        if (start) begin
          load_signs = 1'b1;
          state_d    = ARMED;
        end
      end
      ARMED: begin
        if (start) err_set = 1'b1;
        if (mag_valid) begin
          load_result = 1'b1;
          valid_d     = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        start_ready = result_ready;
        if (mag_valid) err_set = 1'b1;
        if (result_ready) begin
          valid_d = 1'b0;
          if (start) begin
            load_signs = 1'b1;
            state_d    = ARMED;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      neg_q        <= 1'b0;
      en_q         <= 1'b0;
      result       <= '0;
      result_neg   <= 1'b0;
      result_valid <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      state        <= state_d;
      result_valid <= valid_d;
      if (err_set) seq_err <= 1'b1;
      if (load_signs) begin
        neg_q <= x_sign ^ y_sign;
        en_q  <= enable;
      end
      if (load_result) begin
        result     <= result_d;
        result_neg <= neg_d;
      end
    end
  end

endmodule

// File: tb/tb_sign_restore.sv
// Directed bench for sign_restore: sign reapplication, bypass, zero, backpressure,
// back-to-back handoff, protocol errors and asynchronous reset.
module tb_sign_restore;
  localparam int W  = 11;
  localparam int PW = 2*W-1;
  localparam int RW = 2*W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, x_sign, y_sign, enable;
  logic          start_ready;
  logic          mag_valid;
  logic [PW-1:0] mag_product;
  logic [RW-1:0] result;
  logic          result_neg, result_valid, result_ready, seq_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sign_restore #(.W(W), .PW(PW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_sign(x_sign), .y_sign(y_sign),
    .enable(enable), .start_ready(start_ready), .mag_valid(mag_valid),
    .mag_product(mag_product), .result(result), .result_neg(result_neg),
    .result_valid(result_valid), .result_ready(result_ready), .seq_err(seq_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic xs, input logic ys, input logic en);
    start = 1'b1; x_sign = xs; y_sign = ys; enable = en;
    tick();
    start = 1'b0;
  endtask

  task automatic deliver(input logic [PW-1:0] mag);
    mag_valid = 1'b1; mag_product = mag;
    tick();
    mag_valid = 1'b0;
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; x_sign = 0; y_sign = 0; enable = 0;
    mag_valid = 0; mag_product = '0; result_ready = 0;
    #3;
    n_cmp++;
    if ({result, result_neg, result_valid, seq_err, start_ready} !== {22'h0, 4'b0001}) begin
      n_err++;
      $display("FAIL reset: result=%h neg=%b valid=%b err=%b sready=%b, want 0/0/0/0/1",
               result, result_neg, result_valid, seq_err, start_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_neg_small();
    launch(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (start_ready !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL armed_flags: sready=%b valid=%b, want 0/0", start_ready, result_valid);
    end
    deliver(21'd35);
    n_cmp++;
    if (result !== 22'h3FFFDD || result_neg !== 1'b1 || result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL neg5x7: result=%h neg=%b valid=%b, want 3fffdd/1/1", result, result_neg, result_valid);
    end
    release_result();
    n_cmp++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL handoff_idle: valid=%b sready=%b, want 0/1", result_valid, start_ready);
    end
  endtask

  task automatic test_extremes();
    launch(1'b1, 1'b1, 1'b1);
    deliver(21'h100000);
    n_cmp++;
    if (result !== 22'h100000 || result_neg !== 1'b0) begin
      n_err++;
      $display("FAIL max_pos: result=%h neg=%b, want 100000/0", result, result_neg);
    end
    release_result();
    launch(1'b1, 1'b0, 1'b1);
    deliver(21'h100000);
    n_cmp++;
    if (result !== 22'h300000 || result_neg !== 1'b1) begin
      n_err++;
      $display("FAIL max_neg: result=%h neg=%b, want 300000/1", result, result_neg);
    end
    release_result();
  endtask

  task automatic test_zero_bypass();
    launch(1'b1, 1'b0, 1'b1);
    deliver(21'd0);
    n_cmp++;
    if (result !== 22'h0 || result_neg !== 1'b0 || result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL zero: result=%h neg=%b valid=%b, want 0/0/1", result, result_neg, result_valid);
    end
    release_result();
    launch(1'b1, 1'b0, 1'b0);
    deliver(21'd35);
    n_cmp++;
    if (result !== 22'd35 || result_neg !== 1'b0) begin
      n_err++;
      $display("FAIL bypass: result=%h neg=%b, want 000023/0", result, result_neg);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    launch(1'b0, 1'b1, 1'b1);
    deliver(21'd100);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (result !== 22'h3FFF9C || result_neg !== 1'b1 || result_valid !== 1'b1 || start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: result=%h neg=%b valid=%b sready=%b, want 3fff9c/1/1/0",
                 i, result, result_neg, result_valid, start_ready);
      end
      tick();
    end
    result_ready = 1'b1;
    start = 1'b1; x_sign = 1'b1; y_sign = 1'b0; enable = 1'b1;
    #1;
    n_cmp++;
    if (start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_sready: got %b want 1", start_ready);
    end
    tick();
    start = 1'b0; result_ready = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || start_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_armed: valid=%b sready=%b, want 0/0", result_valid, start_ready);
    end
    deliver(21'd6);
    n_cmp++;
    if (result !== 22'h3FFFFA || result_neg !== 1'b1 || result_valid !== 1'b1 || seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_result: result=%h neg=%b valid=%b err=%b, want 3ffffa/1/1/0",
               result, result_neg, result_valid, seq_err);
    end
    release_result();
  endtask

  task automatic test_errors();
    deliver(21'd9);
    n_cmp++;
    if (seq_err !== 1'b1 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_mag: err=%b valid=%b, want 1/0", seq_err, result_valid);
    end
    tick(); tick();
    n_cmp++;
    if (seq_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b want 1", seq_err);
    end
    launch(1'b0, 1'b0, 1'b1);
    launch(1'b1, 1'b0, 1'b1);
    deliver(21'd5);
    n_cmp++;
    if (result !== 22'd5 || result_neg !== 1'b0) begin
      n_err++;
      $display("FAIL armed_start_ignored: result=%h neg=%b, want 000005/0", result, result_neg);
    end
    release_result();
  endtask

  task automatic test_async_reset();
    launch(1'b1, 1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({result, result_neg, result_valid, seq_err, start_ready} !== {22'h0, 4'b0001}) begin
      n_err++;
      $display("FAIL async_reset: result=%h neg=%b valid=%b err=%b sready=%b, want 0/0/0/0/1",
               result, result_neg, result_valid, seq_err, start_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    deliver(21'd7);
    tick();
    n_cmp++;
    if (result_valid !== 1'b0 || result !== 22'h0 || seq_err !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_mag: valid=%b result=%h err=%b, want 0/0/1", result_valid, result, seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_neg_small();
    test_extremes();
    test_zero_bypass();
    test_back_to_back();
    test_errors();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
